demux_1t8_nb: RTL and testbench

Registered 1:8 demultiplexer with a parameterized data width and valid/ready handshakes on both sides. It is the distribution counterpart of the 8:1 select mux. One producer writes a word tagged with a 3-bit lane select, and the word is latched into that lane's holding register until the lane's consumer takes it. It sits between the MCU output-port path and up to eight peripheral sinks, so no peripheral has to be free at the instant of the write.

---
 rtl/demux_1t8_nb.sv | 122 ++++++++++++
 tb/tb_demux_1t8_nb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/demux_1t8_nb.sv
// demux_1t8_nb: registered 1:8 demultiplexer with valid/ready on both sides.
// A producer word tagged with a 3-bit lane select is latched into that lane's
// holding register and held until the lane's consumer takes it.
//
// Optional build macro: DEMUX_CLR_EN -- when defined, a lane's data register
// is zeroed when its word is consumed without a simultaneous reload.
//
// Ports:
//   CLK       system clock, rising edge
//   RST       synchronous active-high reset
//   SEL       destination lane for the input word
//   D_IN      input data word (N bits)
//   IN_VALID  producer presents SEL/D_IN
//   IN_READY  lane SEL can accept this cycle (combinational from SEL/state/READY)
//   D_OUT     packed lane data, lane k at [k*N +: N]
//   VALID     per-lane "holds an unconsumed word"
//   READY     per-lane consumer take strobe
//   ACC_CNT   accepted-word count, wraps modulo 256
module demux_1t8_nb #(
    parameter int unsigned N = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2:0]       SEL,
    input  logic [N-1:0]     D_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [8*N-1:0]   D_OUT,
    output logic [7:0]       VALID,
    input  logic [7:0]       READY,
    output logic [7:0]       ACC_CNT
);

    localparam int unsigned LANES = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    lane_state_e        state_q [LANES];
    lane_state_e        state_d [LANES];
    logic [N-1:0]       data_q  [LANES];
    logic [N-1:0]       data_d  [LANES];
    logic [CNT_W-1:0]   acc_cnt_q;
    logic [CNT_W-1:0]   acc_cnt_d;
    logic               load;

    // Selected lane can take a word if empty or being drained this edge.
    always_comb begin
        IN_READY = (state_q[SEL] == LANE_EMPTY) | READY[SEL];
        load     = IN_VALID & IN_READY;
    end

    // Per-lane next state: independent EMPTY/FULL machines sharing one load port.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            case (state_q[k])
                LANE_EMPTY: begin
                    if (load && (SEL == 3'(k))) begin
                        state_d[k] = LANE_FULL;
                        data_d[k]  = D_IN;
                    end
                end
                LANE_FULL: begin
                    if (load && (SEL == 3'(k))) begin
                        data_d[k]  = D_IN;
                    end else if (READY[k]) begin
                        state_d[k] = LANE_EMPTY;
`ifdef DEMUX_CLR_EN
                        data_d[k]  = '0;
`else
                        data_d[k]  = data_q[k];
`endif
                    end
                end
                default: begin
                    state_d[k] = LANE_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (load) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < LANES; k++) begin
                state_q[k] <= LANE_EMPTY;
                data_q[k]  <= '0;
            end
            acc_cnt_q <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            acc_cnt_q <= acc_cnt_d;
        end
    end

    // Pack lane registers onto the output buses.
    always_comb begin
        D_OUT = '0;
        VALID = '0;
        for (int k = 0; k < LANES; k++) begin
            D_OUT[k*N +: N] = data_q[k];
            VALID[k]        = (state_q[k] == LANE_FULL);
        end
    end

    assign ACC_CNT = acc_cnt_q;

endmodule

// File: tb/tb_demux_1t8_nb.sv
// Directed self-checking bench for demux_1t8_nb (N = 8).
module tb_demux_1t8_nb;

    logic        clk;
    logic        rst;
    logic [2:0]  sel;
    logic [7:0]  d_in;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] d_out;
    logic [7:0]  valid;
    logic [7:0]  ready;
    logic [7:0]  acc_cnt;

    int          total;
    int          bad;
    logic [7:0]  exp_cnt;

    demux_1t8_nb #(.N(8)) dut (
        .CLK      (clk),
        .RST      (rst),
        .SEL      (sel),
        .D_IN     (d_in),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .D_OUT    (d_out),
        .VALID    (valid),
        .READY    (ready),
        .ACC_CNT  (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; sel = 3'd3; d_in = 8'hFF; ready = 8'h00;
        tick; tick;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=%h", valid, 8'h00); end
        total++; if (d_out !== 64'h0) begin bad++; $display("FAIL reset_dout got=%h exp=%h", d_out, 64'h0); end
        total++; if (acc_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h exp=%h", acc_cnt, 8'h00); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        exp_cnt = 8'h00;
    endtask

    task automatic test_basic;
        logic [63:0] exp_dout;
        sel = 3'd5; d_in = 8'hA5; in_valid = 1'b1; ready = 8'h00;
        tick;
        in_valid = 1'b0; exp_cnt = exp_cnt + 8'd1;
        total++; if (valid !== 8'h20) begin bad++; $display("FAIL basic_valid got=%h exp=%h", valid, 8'h20); end
        total++; if (d_out !== 64'h0000_A500_0000_0000) begin bad++; $display("FAIL basic_dout got=%h exp=%h", d_out, 64'h0000_A500_0000_0000); end
        total++; if (acc_cnt !== exp_cnt) begin bad++; $display("FAIL basic_cnt got=%h exp=%h", acc_cnt, exp_cnt); end
        // idle input must change nothing
        sel = 3'd1; d_in = 8'hEE;
        tick;
        total++; if (valid !== 8'h20) begin bad++; $display("FAIL idle_valid got=%h exp=%h", valid, 8'h20); end
        total++; if (acc_cnt !== exp_cnt) begin bad++; $display("FAIL idle_cnt got=%h exp=%h", acc_cnt, exp_cnt); end
        // consume lane 5
        ready = 8'hFF;
        tick;
        ready = 8'h00;
`ifdef DEMUX_CLR_EN
        exp_dout = 64'h0;
`else
        exp_dout = 64'h0000_A500_0000_0000;
`endif
        total++; if (valid !== 8'h00) begin bad++; $display("FAIL basic_consume_valid got=%h exp=%h", valid, 8'h00); end
        total++; if (d_out !== exp_dout) begin bad++; $display("FAIL basic_consume_dout got=%h exp=%h", d_out, exp_dout); end
    endtask

    task automatic test_backpressure;
        sel = 3'd2; d_in = 8'h11; in_valid = 1'b1; ready = 8'h00;
        tick;
        exp_cnt = exp_cnt + 8'd1;
        d_in = 8'h22;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low got=%b exp=0", in_ready); end
        tick;
        total++; if (d_out[23:16] !== 8'h11) begin bad++; $display("FAIL bp_hold_data got=%h exp=%h", d_out[23:16], 8'h11); end
        total++; if (acc_cnt !== exp_cnt) begin bad++; $display("FAIL bp_hold_cnt got=%h exp=%h", acc_cnt, exp_cnt); end
        ready = 8'h04;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_high got=%b exp=1", in_ready); end
        tick;
        in_valid = 1'b0; ready = 8'h00; exp_cnt = exp_cnt + 8'd1;
        total++; if (d_out[23:16] !== 8'h22) begin bad++; $display("FAIL bp_reload_data got=%h exp=%h", d_out[23:16], 8'h22); end
        total++; if (valid !== 8'h04) begin bad++; $display("FAIL bp_reload_valid got=%h exp=%h", valid, 8'h04); end
        total++; if (acc_cnt !== exp_cnt) begin bad++; $display("FAIL bp_reload_cnt got=%h exp=%h", acc_cnt, exp_cnt); end
        ready = 8'h04;
        tick;
        ready = 8'h00;
        total++; if (valid !== 8'h00) begin bad++; $display("FAIL bp_drain_valid got=%h exp=%h", valid, 8'h00); end
    endtask

    task automatic test_rotation;
        ready = 8'h00;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k); d_in = 8'h10 + 8'(k); in_valid = 1'b1;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rot_in_ready lane=%0d got=%b exp=1", k, in_ready); end
            tick;
            exp_cnt = exp_cnt + 8'd1;
        end
        in_valid = 1'b0;
        total++; if (valid !== 8'hFF) begin bad++; $display("FAIL rot_valid got=%h exp=%h", valid, 8'hFF); end
        total++; if (d_out !== 64'h1716_1514_1312_1110) begin bad++; $display("FAIL rot_dout got=%h exp=%h", d_out, 64'h1716_1514_1312_1110); end
        total++; if (acc_cnt !== exp_cnt) begin bad++; $display("FAIL rot_cnt got=%h exp=%h", acc_cnt, exp_cnt); end
        sel = 3'd0; d_in = 8'h99; in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rot_stall_in_ready got=%b exp=0", in_ready); end
        tick;
        in_valid = 1'b0;
        total++; if (d_out[7:0] !== 8'h10) begin bad++; $display("FAIL rot_stall_data got=%h exp=%h", d_out[7:0], 8'h10); end
        total++; if (acc_cnt !== exp_cnt) begin bad++; $display("FAIL rot_stall_cnt got=%h exp=%h", acc_cnt, exp_cnt); end
        ready = 8'hFF;
        tick;
        ready = 8'h00;
        total++; if (valid !== 8'h00) begin bad++; $display("FAIL rot_drain_valid got=%h exp=%h", valid, 8'h00); end
    endtask

    task automatic test_wrap;
        int stalls;
        stalls = 0;
        ready = 8'hFF; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sel = 3'(i); d_in = 8'(i);
            #1;
            if (in_ready !== 1'b1) stalls++;
            tick;
        end
        in_valid = 1'b0;
        total++; if (stalls !== 0) begin bad++; $display("FAIL wrap_in_ready stalls got=%0d exp=0", stalls); end
        total++; if (acc_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_cnt got=%h exp=%h", acc_cnt, exp_cnt); end
        tick;
        ready = 8'h00;
        total++; if (valid !== 8'h00) begin bad++; $display("FAIL wrap_drain_valid got=%h exp=%h", valid, 8'h00); end
    endtask

    task automatic test_clear;
        logic [7:0] exp_lane;
        sel = 3'd7; d_in = 8'h3C; in_valid = 1'b1; ready = 8'h00;
        tick;
        in_valid = 1'b0; exp_cnt = exp_cnt + 8'd1;
        total++; if (valid !== 8'h80) begin bad++; $display("FAIL clr_load_valid got=%h exp=%h", valid, 8'h80); end
        total++; if (d_out[63:56] !== 8'h3C) begin bad++; $display("FAIL clr_load_data got=%h exp=%h", d_out[63:56], 8'h3C); end
        ready = 8'h80;
        tick;
        ready = 8'h00;
`ifdef DEMUX_CLR_EN
        exp_lane = 8'h00;
`else
        exp_lane = 8'h3C;
`endif
        total++; if (valid !== 8'h00) begin bad++; $display("FAIL clr_consume_valid got=%h exp=%h", valid, 8'h00); end
        total++; if (d_out[63:56] !== exp_lane) begin bad++; $display("FAIL clr_consume_data got=%h exp=%h", d_out[63:56], exp_lane); end
        total++; if (acc_cnt !== exp_cnt) begin bad++; $display("FAIL clr_cnt got=%h exp=%h", acc_cnt, exp_cnt); end
    endtask

    initial begin
        total = 0; bad = 0; exp_cnt = 8'h00;
        rst = 1'b1; sel = 3'd0; d_in = 8'h00; in_valid = 1'b0; ready = 8'h00;
        test_reset;
        test_basic;
        test_backpressure;
        test_rotation;
        test_wrap;
        test_clear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
